// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: packs the Game Boy LCD pixel stream into a double-banked framebuffer
// Ports:
//   clk, rst                 clk_gb domain clock, asynchronous active-high reset
//   gb_hs, gb_vs, gb_cpl     LCD line end, frame end and pixel latch (rising edges)
//   gb_pixel, gb_valid       2bpp shade and its valid flag, sampled with gb_cpl
//   fb_we, fb_addr, fb_wdata framebuffer byte write {bank, y*H/4 + x/4}, four pixels per byte
//   disp_bank, frame_done    bank of the last complete frame and its update pulse
//   frames_dropped, overflow saturating incomplete-frame count, sticky out-of-range flag
module gb_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES = 144,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gb_hs,
  input  logic              gb_vs,
  input  logic              gb_cpl,
  input  logic [1:0]        gb_pixel,
  input  logic              gb_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              disp_bank,
  output logic              frame_done,
  output logic [7:0]        frames_dropped,
  output logic              overflow
);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam int BW = ADDR_W - 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_MAX = YW'(V_LINES);
  localparam logic [BW-1:0] BPL = BW'(H_PIXELS / 4);
  logic hs_q, hs_d, vs_q, vs_d, cpl_q, cpl_d, valid_q;
  logic [1:0] pix_q;
  logic [XW-1:0] x, x_a, x_n;
  logic [YW-1:0] y, y_h, y_n;
  logic [7:0] pack, pack_a, pack_n;
  logic wr_bank;
  logic hs_rise, vs_rise, cpl_rise, accept, drop, full, wr, complete;
  logic [ADDR_W-1:0] wr_addr;
  // write request staged once so fb_we lands two clocks after gb_cpl is first sampled
  logic wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0] wr_data_q;
  // events resolve in order pixel -> hs -> vs; a flush on hs/vs merges with a just-completed byte
  // because a completed byte leaves x[1:0] == 0, so at most one write per clock
  always_comb begin
    hs_rise = hs_q & ~hs_d;
    vs_rise = vs_q & ~vs_d;
    cpl_rise = cpl_q & ~cpl_d;
    accept = cpl_rise & valid_q & (x < X_MAX) & (y < Y_MAX);
    drop = cpl_rise & valid_q & ~accept;
    pack_a = pack;
    if (accept) pack_a[{x[1:0], 1'b0} +: 2] = pix_q;
    x_a = accept ? x + XW'(1) : x;
    full = accept & (x[1:0] == 2'd3);
    wr = full | ((hs_rise | vs_rise) & (x_a[1:0] != 2'd0));
    y_h = (hs_rise && y != Y_MAX) ? y + YW'(1) : y;
    complete = vs_rise & (y_h == Y_MAX);
    x_n = (hs_rise | vs_rise) ? '0 : x_a;
    y_n = vs_rise ? '0 : y_h;
    pack_n = wr ? 8'd0 : pack_a;
    wr_addr = {wr_bank, BW'(y) * BPL + BW'(x >> 2)};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {hs_q, hs_d, vs_q, vs_d, cpl_q, cpl_d, valid_q} <= '0;
      pix_q <= '0;
      x <= '0;
      y <= '0;
      pack <= '0;
      wr_bank <= 1'b1;
      disp_bank <= 1'b0;
      frame_done <= 1'b0;
      frames_dropped <= '0;
      overflow <= 1'b0;
      wr_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_wdata <= '0;
    end else begin
      hs_q <= gb_hs;
      hs_d <= hs_q;
      vs_q <= gb_vs;
      vs_d <= vs_q;
      cpl_q <= gb_cpl;
      cpl_d <= cpl_q;
      valid_q <= gb_valid;
      pix_q <= gb_pixel;
      x <= x_n;
      y <= y_n;
      pack <= pack_n;
      wr_q <= wr;
      wr_addr_q <= wr_addr;
      wr_data_q <= pack_a;
      fb_we <= wr_q;
      fb_addr <= wr_addr_q;
      fb_wdata <= wr_data_q;
      frame_done <= complete;
      if (complete) begin
        disp_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
      if (vs_rise && !complete && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb_gb_lcd_capture: directed vectors and corner sequences for gb_lcd_capture
module tb_gb_lcd_capture;
  logic clk, rst, gb_hs, gb_vs, gb_cpl, gb_valid;
  logic [1:0] gb_pixel;
  logic fb_we, disp_bank, frame_done, overflow;
  logic [13:0] fb_addr;
  logic [7:0] fb_wdata, frames_dropped;
  int n_cmp = 0, n_bad = 0, fdone_cnt = 0;
  logic [13:0] qa[$];
  logic [7:0] qd[$];
  typedef struct {
    int npix;
    logic [2:0] pv;
    logic vld;
    logic [1:0] term;
    int n;
    logic [13:0] a0;
    logic [7:0] d0;
    logic [13:0] a1;
    logic [7:0] d1;
    logic ovf;
    logic [7:0] fd;
  } vec_t;
  vec_t tbl[7];
  gb_lcd_capture dut (
    .clk(clk), .rst(rst), .gb_hs(gb_hs), .gb_vs(gb_vs), .gb_cpl(gb_cpl),
    .gb_pixel(gb_pixel), .gb_valid(gb_valid), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .disp_bank(disp_bank), .frame_done(frame_done),
    .frames_dropped(frames_dropped), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (fb_we) begin
      qa.push_back(fb_addr);
      qd.push_back(fb_wdata);
    end
    if (frame_done) fdone_cnt++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  task automatic ev(input logic [1:0] p, input logic vld, input logic c, input logic h, input logic v);
    @(posedge clk);
    #1;
    gb_pixel = p;
    gb_valid = vld;
    gb_cpl = c;
    gb_hs = h;
    gb_vs = v;
    @(posedge clk);
    #1;
    gb_cpl = 1'b0;
    gb_valid = 1'b0;
    gb_hs = 1'b0;
    gb_vs = 1'b0;
  endtask
  task automatic quad();
    for (int i = 0; i < 4; i++) ev(2'(i), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic lines(input int n);
    for (int i = 0; i < n; i++) ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic do_rst();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    int f0, bad_a, bad_d;
    tbl[0] = '{6, 3'd3, 1'b1, 2'd1, 2, 14'd8192, 8'hFF, 14'd8193, 8'h0F, 1'b0, 8'd0};
    tbl[1] = '{4, 3'd4, 1'b1, 2'd1, 1, 14'd8232, 8'hE4, 14'd8232, 8'hE4, 1'b0, 8'd0};
    tbl[2] = '{170, 3'd4, 1'b1, 2'd1, 40, 14'd8272, 8'hE4, 14'd8311, 8'hE4, 1'b1, 8'd0};
    tbl[3] = '{3, 3'd2, 1'b1, 2'd1, 1, 14'd8312, 8'h2A, 14'd8312, 8'h2A, 1'b1, 8'd0};
    tbl[4] = '{4, 3'd3, 1'b0, 2'd1, 0, 14'd0, 8'h00, 14'd0, 8'h00, 1'b1, 8'd0};
    tbl[5] = '{5, 3'd1, 1'b1, 2'd2, 2, 14'd8392, 8'h55, 14'd8393, 8'h01, 1'b1, 8'd1};
    tbl[6] = '{2, 3'd3, 1'b1, 2'd3, 1, 14'd8192, 8'h0F, 14'd8192, 8'h0F, 1'b1, 8'd2};
    {gb_hs, gb_vs, gb_cpl, gb_valid} = '0;
    gb_pixel = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_wdata", fb_wdata, 0);
    chk("rst_disp", disp_bank, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_dropped", frames_dropped, 0);
    chk("rst_ovf", overflow, 0);
    // write latency, then asynchronous reset while fb_we is high
    for (int i = 0; i < 3; i++) ev(2'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    gb_pixel = 2'd3;
    gb_valid = 1'b1;
    gb_cpl = 1'b1;
    @(posedge clk);
    #1;
    gb_cpl = 1'b0;
    gb_valid = 1'b0;
    chk("lat_e0", fb_we, 0);
    @(posedge clk);
    #1 chk("lat_e1", fb_we, 0);
    @(posedge clk);
    #1 chk("lat_e2", fb_we, 1);
    chk("lat_addr", fb_addr, 14'd8192);
    chk("lat_data", fb_wdata, 8'hE4);
    #2 rst = 1'b1;
    #1 chk("async_we_clear", fb_we, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // reset mid-frame at line 50, x = 2
    lines(50);
    ev(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    ev(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("midrst_we", fb_we, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    qa.delete();
    qd.delete();
    quad();
    settle();
    chk("midrst_n", qa.size(), 1);
    if (qa.size() > 0) begin
      chk("midrst_addr", qa[0], 14'd8192);
      chk("midrst_data", qd[0], 8'hE4);
    end
    chk("midrst_disp", disp_bank, 0);
    // table of line-level vectors from a fresh reset
    do_rst();
    foreach (tbl[r]) begin
      qa.delete();
      qd.delete();
      for (int i = 0; i < tbl[r].npix; i++)
        ev(tbl[r].pv == 3'd4 ? 2'(i) : tbl[r].pv[1:0], tbl[r].vld, 1'b1, 1'b0, 1'b0);
      ev(2'd0, 1'b0, 1'b0, tbl[r].term[0], tbl[r].term[1]);
      settle();
      chk($sformatf("row%0d_n", r), qa.size(), tbl[r].n);
      if (qa.size() > 0 && tbl[r].n > 0) begin
        chk($sformatf("row%0d_a0", r), qa[0], tbl[r].a0);
        chk($sformatf("row%0d_d0", r), qd[0], tbl[r].d0);
        chk($sformatf("row%0d_a1", r), qa[$], tbl[r].a1);
        chk($sformatf("row%0d_d1", r), qd[$], tbl[r].d1);
      end
      chk($sformatf("row%0d_ovf", r), overflow, tbl[r].ovf);
      chk($sformatf("row%0d_fd", r), frames_dropped, tbl[r].fd);
      chk($sformatf("row%0d_disp", r), disp_bank, 0);
    end
    // overflow persists through a later complete frame
    f0 = fdone_cnt;
    lines(144);
    ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("persist_ovf", overflow, 1);
    chk("persist_disp", disp_bank, 1);
    chk("persist_fdone", fdone_cnt - f0, 1);
    // 4th pixel of a byte with hs and vs in the same cycle, then pixel with hs alone
    f0 = fdone_cnt;
    qa.delete();
    qd.delete();
    lines(143);
    for (int i = 0; i < 3; i++) ev(2'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    ev(2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    quad();
    for (int i = 0; i < 3; i++) ev(2'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    ev(2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    quad();
    settle();
    chk("coin_n", qa.size(), 4);
    if (qa.size() == 4) begin
      chk("coin_a0", qa[0], 14'd5720);
      chk("coin_a1", qa[1], 14'd8192);
      chk("coin_a2", qa[2], 14'd8193);
      chk("coin_a3", qa[3], 14'd8232);
      chk("coin_d", {qd[0], qd[1], qd[2], qd[3]}, 32'hE4E4E4E4);
    end
    chk("coin_fdone", fdone_cnt - f0, 1);
    chk("coin_disp", disp_bank, 0);
    // full 160x144 frame
    do_rst();
    f0 = fdone_cnt;
    qa.delete();
    qd.delete();
    for (int l = 0; l < 144; l++) begin
      for (int i = 0; i < 160; i++) ev(2'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    bad_a = 0;
    bad_d = 0;
    foreach (qa[k]) begin
      if (qa[k] !== 14'(8192 + k)) bad_a++;
      if (qd[k] !== 8'hE4) bad_d++;
    end
    chk("full_n", qa.size(), 5760);
    chk("full_addr_errs", bad_a, 0);
    chk("full_data_errs", bad_d, 0);
    if (qa.size() > 0) chk("full_last_addr", qa[$], 14'd13951);
    chk("full_disp", disp_bank, 1);
    chk("full_fdone", fdone_cnt - f0, 1);
    chk("full_ovf", overflow, 0);
    chk("full_fd", frames_dropped, 0);
    // short frame, then a full frame swaps normally
    f0 = fdone_cnt;
    qa.delete();
    qd.delete();
    lines(100);
    ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("short_fd", frames_dropped, 1);
    chk("short_disp", disp_bank, 1);
    chk("short_fdone", fdone_cnt - f0, 0);
    quad();
    lines(144);
    ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    quad();
    settle();
    chk("swap_n", qa.size(), 2);
    if (qa.size() == 2) begin
      chk("short_bank_kept", qa[0], 14'd0);
      chk("swap_bank", qa[1], 14'd8192);
    end
    chk("swap_disp", disp_bank, 0);
    chk("swap_fdone", fdone_cnt - f0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
